// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM type and helpers for the oversampling UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int MIN_OVERSAMPLE = 8;
  function automatic int div_calc(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
  function automatic logic os_ok(input int os);
    return os >= MIN_OVERSAMPLE && os % 2 == 0;
  endfunction
  function automatic logic parity_calc(input logic [8:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through sync FIFO with occupancy count and drop flag
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    valid = count_q != '0;
    do_pop = pop & valid;
    do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    drop = push & ~do_push;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    rdata = valid ? mem_q[rd_q] : '0;
    count = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/uart_rx_os_fifo.sv
// uart_rx_os_fifo: oversampling UART receiver with majority vote, error tagging and receive FIFO
module uart_rx_os_fifo
  import uart_pkg::*;
#(
  parameter int RX_SYS_CLK = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          rx_clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          parity_en,
  input  logic                          odd_r_even_parity,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_parity_error,
  output logic                          m_framing_error,
  output logic                          done,
  output logic                          break_det,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = div_calc(RX_SYS_CLK, BAUD_RATE, OVERSAMPLE);
  localparam int DW = $clog2(DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int BW = 4;
  if (!os_ok(OVERSAMPLE) || DIV < 1 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2
      || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx_os_fifo: illegal parameter combination");
  end
  rx_state_e state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] s_q, s_d;
  logic [1:0] smp_q, smp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic perr_q, perr_d, ferr_q, ferr_d, hi_q, hi_d, even_q, even_d, pen_q, pen_d;
  logic done_q, done_d, brk_q, brk_d, ovr_q, ovr_d;
  logic rx_s, fall, tick, act, maj, push, drop;
  logic [DATA_WIDTH+1:0] word, head;
  always_comb begin
    sync_d = {sync_q[1:0], rx};
    rx_s = sync_q[1];
    fall = sync_q[2] & ~sync_q[1];
    tick = div_q == DW'(DIV - 1);
    act = tick && s_q == SW'(MID + 1);
    maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    div_d = tick ? '0 : div_q + DW'(1);
    s_d = !tick ? s_q : s_q == SW'(OVERSAMPLE - 1) ? '0 : s_q + SW'(1);
    smp_d[0] = tick && s_q == SW'(MID - 1) ? rx_s : smp_q[0];
    smp_d[1] = tick && s_q == SW'(MID) ? rx_s : smp_q[1];
    state_d = state_q;
    bit_d = bit_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    hi_d = hi_q;
    even_d = even_q;
    pen_d = pen_q;
    push = 1'b0;
    brk_d = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        div_d = '0;
        s_d = '0;
      end
      START: if (act) begin
        state_d = maj ? IDLE : DATA;
        bit_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        hi_d = 1'b0;
        even_d = odd_r_even_parity;
        pen_d = parity_en;
      end
      DATA: if (act) begin
        data_d = {maj, data_q[DATA_WIDTH-1:1]};
        bit_d = bit_q == BW'(DATA_WIDTH - 1) ? '0 : bit_q + BW'(1);
        state_d = bit_q != BW'(DATA_WIDTH - 1) ? DATA : pen_q ? PARITY : STOP;
      end
      PARITY: if (act) begin
        perr_d = maj != parity_calc(9'(data_q), even_q);
        state_d = STOP;
      end
      STOP: if (act) begin
        ferr_d = ferr_q | ~maj;
        hi_d = hi_q | maj;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(STOP_BITS - 1)) begin
          // leave mid stop bit so the next start edge is never missed
          state_d = IDLE;
          push = 1'b1;
          brk_d = data_q == '0 && !hi_d;
        end
      end
      default: state_d = IDLE;
    endcase
    word = {perr_d, ferr_d, data_d};
    done_d = push;
  end
  assign ovr_d = drop ? 1'b1 : overrun_clr ? 1'b0 : ovr_q;
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 3'b111;
      div_q <= '0;
      s_q <= '0;
      smp_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      hi_q <= 1'b0;
      even_q <= 1'b0;
      pen_q <= 1'b0;
      done_q <= 1'b0;
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      div_q <= div_d;
      s_q <= s_d;
      smp_q <= smp_d;
      bit_q <= bit_d;
      data_q <= data_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      hi_q <= hi_d;
      even_q <= even_d;
      pen_q <= pen_d;
      done_q <= done_d;
      brk_q <= brk_d;
      ovr_q <= ovr_d;
    end
  end
  uart_rx_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(rx_clk),
    .rst(rst),
    .push(push),
    .wdata(word),
    .pop(m_ready),
    .rdata(head),
    .valid(m_valid),
    .drop(drop),
    .count(fifo_count)
  );
  assign {m_parity_error, m_framing_error, m_data} = head;
  assign done = done_q;
  assign break_det = brk_q;
  assign overrun = ovr_q;
endmodule
